// File: rtl/sdram_responder.sv
// SDR SDRAM device emulator: decodes SDRAM commands, tracks open rows per bank, honours the
// mode register (CL/BL/write-burst mode) and serves 16-bit data from an internal RAM.
module sdram_responder #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter logic [11:0] RESET_MODE     = 12'h032
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cke,
  input  logic        i_cs_n,
  input  logic        i_ras,
  input  logic        i_cas,
  input  logic        i_we,
  input  logic [11:0] i_address,
  input  logic [1:0]  i_bank,
  input  logic [15:0] i_data_in,
  input  logic [1:0]  i_data_mask,
  output logic [15:0] o_data_out,
  output logic        o_data_oe,
  output logic        o_init_done,
  output logic        o_protocol_error,
  output logic [15:0] o_refresh_count
);

  localparam int unsigned Depth = 2 ** MEM_ADDR_WIDTH;
  typedef logic [MEM_ADDR_WIDTH-1:0] addr_t;

  // Flat RAM index is the low bits of {bank, row, col}, so addresses alias.
  function automatic addr_t mem_addr(input logic [1:0] b, input logic [11:0] row,
                                     input logic [7:0] col);
    logic [21:0] full;
    full = {b, row, col};
    return full[MEM_ADDR_WIDTH-1:0];
  endfunction

  // Sequential column order wrapping inside the BL-aligned block.
  function automatic logic [7:0] beat_col(input logic [7:0] base, input logic [3:0] idx,
                                          input logic [3:0] bl);
    logic [7:0] m;
    m = {4'b0000, bl - 4'd1};
    return (base & ~m) | ((base + {4'b0000, idx}) & m);
  endfunction

  logic [15:0] r_mem [Depth];

  logic [11:0] r_mode;
  logic [3:0]  r_bank_act;
  logic [11:0] r_row [4];

  logic [3:0]  r_rd_rem, r_rd_idx, r_rd_bl;
  logic [1:0]  r_rd_bank;
  logic [11:0] r_rd_row;
  logic [7:0]  r_rd_col;

  logic [3:0]  r_wr_rem, r_wr_idx, r_wr_bl;
  logic [1:0]  r_wr_bank;
  logic [11:0] r_wr_row;
  logic [7:0]  r_wr_col;

  logic [2:0]  r_pipe_vld;
  addr_t       r_pipe_addr [3];

  logic        w_cmd_en;
  logic [2:0]  w_cmd;
  logic        w_act, w_rd, w_wr, w_bst, w_pre, w_ar, w_mrs;
  logic        w_sel_open, w_any_open, w_mrs_legal;
  logic        w_act_ok, w_rd_ok, w_wr_ok, w_ar_ok, w_mrs_ok, w_err;
  logic        w_pre_rd, w_pre_wr;
  logic [3:0]  w_bl;
  logic        w_rd_issue, w_mem_we, w_out_vld;
  addr_t       w_rd_addr, w_mem_addr, w_out_addr;
  logic        unused_mode;

  assign w_cmd_en = i_cke & ~i_cs_n;
  assign w_cmd    = {i_ras, i_cas, i_we};
  assign w_act    = w_cmd_en && (w_cmd == 3'b011);
  assign w_rd     = w_cmd_en && (w_cmd == 3'b101);
  assign w_wr     = w_cmd_en && (w_cmd == 3'b100);
  assign w_bst    = w_cmd_en && (w_cmd == 3'b110);
  assign w_pre    = w_cmd_en && (w_cmd == 3'b010);
  assign w_ar     = w_cmd_en && (w_cmd == 3'b001);
  assign w_mrs    = w_cmd_en && (w_cmd == 3'b000);

  assign w_sel_open  = r_bank_act[i_bank];
  assign w_any_open  = |r_bank_act;
  assign w_mrs_legal = ((i_address[6:4] == 3'd2) || (i_address[6:4] == 3'd3)) && !i_address[2];

  assign w_act_ok = w_act & ~w_sel_open;
  assign w_rd_ok  = w_rd & w_sel_open;
  assign w_wr_ok  = w_wr & w_sel_open;
  assign w_ar_ok  = w_ar & ~w_any_open;
  assign w_mrs_ok = w_mrs & ~w_any_open & w_mrs_legal;
  assign w_err    = (w_act & w_sel_open) | (w_rd & ~w_sel_open) | (w_wr & ~w_sel_open) |
                    (w_ar & w_any_open) | (w_mrs & ~w_mrs_ok);

  assign w_bl     = 4'd1 << r_mode[1:0];
  assign w_pre_rd = w_pre & (i_address[10] | (i_bank == r_rd_bank));
  assign w_pre_wr = w_pre & (i_address[10] | (i_bank == r_wr_bank));

  assign unused_mode = ^{r_mode[11:10], r_mode[8:7], r_mode[3:2]};

  always_comb begin
    w_rd_issue = 1'b0;
    w_rd_addr  = '0;
    if (w_rd_ok) begin
      w_rd_issue = 1'b1;
      w_rd_addr  = mem_addr(i_bank, r_row[i_bank], i_address[7:0]);
    end else if ((r_rd_rem != 4'd0) && !(w_wr_ok | w_bst | w_pre_rd)) begin
      w_rd_issue = 1'b1;
      w_rd_addr  = mem_addr(r_rd_bank, r_rd_row, beat_col(r_rd_col, r_rd_idx, r_rd_bl));
    end
  end

  // BST still lets the beat on its own edge be written; READ/PRE cut the burst immediately.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    if (w_wr_ok) begin
      w_mem_we   = 1'b1;
      w_mem_addr = mem_addr(i_bank, r_row[i_bank], i_address[7:0]);
    end else if ((r_wr_rem != 4'd0) && !(w_rd_ok | w_pre_wr)) begin
      w_mem_we   = 1'b1;
      w_mem_addr = mem_addr(r_wr_bank, r_wr_row, beat_col(r_wr_col, r_wr_idx, r_wr_bl));
    end
  end

  always_comb begin
    if (r_mode[4]) begin
      w_out_vld  = r_pipe_vld[2];
      w_out_addr = r_pipe_addr[2];
    end else begin
      w_out_vld  = r_pipe_vld[1];
      w_out_addr = r_pipe_addr[1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_cke && w_mem_we) begin
      if (!i_data_mask[0]) r_mem[w_mem_addr][7:0]  <= i_data_in[7:0];
      if (!i_data_mask[1]) r_mem[w_mem_addr][15:8] <= i_data_in[15:8];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode           <= RESET_MODE;
      r_bank_act       <= '0;
      for (int i = 0; i < 4; i++) r_row[i] <= '0;
      o_init_done      <= 1'b0;
      o_protocol_error <= 1'b0;
      o_refresh_count  <= '0;
    end else if (i_cke) begin
      o_protocol_error <= w_err;
      if (w_act_ok) begin
        r_bank_act[i_bank] <= 1'b1;
        r_row[i_bank]      <= i_address;
      end
      if (w_pre) begin
        if (i_address[10]) r_bank_act <= '0;
        else               r_bank_act[i_bank] <= 1'b0;
      end
      if (w_ar_ok) o_refresh_count <= o_refresh_count + 16'd1;
      if (w_mrs_ok) begin
        r_mode      <= i_address;
        o_init_done <= 1'b1;
      end
    end else begin
      o_protocol_error <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_rem  <= '0;
      r_rd_idx  <= '0;
      r_rd_bl   <= '0;
      r_rd_bank <= '0;
      r_rd_row  <= '0;
      r_rd_col  <= '0;
      r_wr_rem  <= '0;
      r_wr_idx  <= '0;
      r_wr_bl   <= '0;
      r_wr_bank <= '0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
    end else if (i_cke) begin
      if (w_rd_ok) begin
        r_rd_rem  <= w_bl - 4'd1;
        r_rd_idx  <= 4'd1;
        r_rd_bl   <= w_bl;
        r_rd_bank <= i_bank;
        r_rd_row  <= r_row[i_bank];
        r_rd_col  <= i_address[7:0];
      end else if (r_rd_rem != 4'd0) begin
        if (w_wr_ok | w_bst | w_pre_rd) begin
          r_rd_rem <= '0;
        end else begin
          r_rd_rem <= r_rd_rem - 4'd1;
          r_rd_idx <= r_rd_idx + 4'd1;
        end
      end
      if (w_wr_ok) begin
        r_wr_rem  <= r_mode[9] ? 4'd0 : w_bl - 4'd1;
        r_wr_idx  <= 4'd1;
        r_wr_bl   <= w_bl;
        r_wr_bank <= i_bank;
        r_wr_row  <= r_row[i_bank];
        r_wr_col  <= i_address[7:0];
      end else if (r_wr_rem != 4'd0) begin
        if (w_bst | w_rd_ok | w_pre_wr) begin
          r_wr_rem <= '0;
        end else begin
          r_wr_rem <= r_wr_rem - 4'd1;
          r_wr_idx <= r_wr_idx + 4'd1;
        end
      end
    end
  end

  // CL pipeline: beat issued at edge N is read from RAM and driven at edge N+CL.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < 3; i++) r_pipe_addr[i] <= '0;
      o_data_oe  <= 1'b0;
      o_data_out <= '0;
    end else if (i_cke) begin
      r_pipe_addr[0] <= w_rd_addr;
      r_pipe_addr[1] <= r_pipe_addr[0];
      r_pipe_addr[2] <= r_pipe_addr[1];
      if (w_wr_ok) begin
        r_pipe_vld <= '0;
        o_data_oe  <= 1'b0;
        o_data_out <= '0;
      end else begin
        r_pipe_vld <= {r_pipe_vld[1:0], w_rd_issue};
        o_data_oe  <= w_out_vld;
        o_data_out <= w_out_vld ? r_mem[w_out_addr] : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder: init, bursts, wrap order, masking,
// protocol errors, burst termination and asynchronous reset.
module tb_sdram_responder;

  localparam logic [2:0] CmdNop = 3'b111;
  localparam logic [2:0] CmdAct = 3'b011;
  localparam logic [2:0] CmdRd  = 3'b101;
  localparam logic [2:0] CmdWr  = 3'b100;
  localparam logic [2:0] CmdBst = 3'b110;
  localparam logic [2:0] CmdPre = 3'b010;
  localparam logic [2:0] CmdAr  = 3'b001;
  localparam logic [2:0] CmdMrs = 3'b000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke, cs_n, ras, cas, we;
  logic [11:0] address;
  logic [1:0]  bank;
  logic [15:0] data_in;
  logic [1:0]  data_mask;
  logic [15:0] data_out;
  logic        data_oe, init_done, protocol_error;
  logic [15:0] refresh_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdram_responder #(
    .MEM_ADDR_WIDTH(10),
    .RESET_MODE    (12'h032)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cke           (cke),
    .i_cs_n          (cs_n),
    .i_ras           (ras),
    .i_cas           (cas),
    .i_we            (we),
    .i_address       (address),
    .i_bank          (bank),
    .i_data_in       (data_in),
    .i_data_mask     (data_mask),
    .o_data_out      (data_out),
    .o_data_oe       (data_oe),
    .o_init_done     (init_done),
    .o_protocol_error(protocol_error),
    .o_refresh_count (refresh_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a command before the edge, then return 1 time unit after it.
  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                     input logic [15:0] d, input logic [1:0] m);
    {ras, cas, we} = c;
    bank = b;
    address = a;
    data_in = d;
    data_mask = m;
    @(posedge clk);
    #1;
    {ras, cas, we} = CmdNop;
    data_mask = 2'b00;
  endtask

  task automatic nop();
    cmd(CmdNop, 2'd0, 12'd0, 16'd0, 2'b00);
  endtask

  // Run n idle cycles after a READ; report beat count and cycle of first beat.
  task automatic count_beats(input int n, output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      nop();
      if (data_oe) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp4 [4];
    logic [15:0] exp8 [8];
    logic [15:0] d0, d1;
    int cnt, first, oe_seen, perr_cnt;

    rst_n = 1'b0;
    cke = 1'b1;
    cs_n = 1'b0;
    {ras, cas, we} = CmdNop;
    address = '0;
    bank = '0;
    data_in = '0;
    data_mask = '0;
    #3;
    check("rst_oe", data_oe, 0);
    check("rst_dout", data_out, 0);
    check("rst_init", init_done, 0);
    check("rst_perr", protocol_error, 0);
    check("rst_refresh", refresh_count, 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Init, open bank 1 row 5, BL=4 write, CL=3 read back.
    cmd(CmdMrs, 2'd0, 12'h032, 16'h0, 2'b00);
    check("init_done", init_done, 1);
    cmd(CmdAct, 2'd1, 12'd5, 16'h0, 2'b00);
    exp4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    cmd(CmdWr, 2'd1, 12'd0, exp4[0], 2'b00);
    for (int k = 1; k < 4; k++) cmd(CmdNop, 2'd0, 12'd0, exp4[k], 2'b00);
    cmd(CmdRd, 2'd1, 12'd0, 16'h0, 2'b00);
    nop();
    check("cl3_oe_n1", data_oe, 0);
    nop();
    check("cl3_oe_n2", data_oe, 0);
    for (int k = 0; k < 4; k++) begin
      nop();
      check($sformatf("bl4_oe%0d", k), data_oe, 1);
      check($sformatf("bl4_dat%0d", k), data_out, exp4[k]);
    end
    nop();
    check("bl4_oe_end", data_oe, 0);

    // CL=2 BL=8, wrap order from col 6.
    cmd(CmdPre, 2'd0, 12'h400, 16'h0, 2'b00);
    cmd(CmdMrs, 2'd0, 12'h023, 16'h0, 2'b00);
    cmd(CmdAct, 2'd1, 12'd5, 16'h0, 2'b00);
    cmd(CmdWr, 2'd1, 12'd0, 16'h0A00, 2'b00);
    for (int k = 1; k < 8; k++) cmd(CmdNop, 2'd0, 12'd0, 16'h0A00 + 16'(k), 2'b00);
    exp8 = '{16'h0A06, 16'h0A07, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05};
    cmd(CmdRd, 2'd1, 12'd6, 16'h0, 2'b00);
    nop();
    check("cl2_oe_n1", data_oe, 0);
    for (int k = 0; k < 8; k++) begin
      nop();
      check($sformatf("bl8_oe%0d", k), data_oe, 1);
      check($sformatf("bl8_dat%0d", k), data_out, exp8[k]);
    end
    nop();
    check("bl8_oe_end", data_oe, 0);

    // Single-beat writes, byte mask.
    cmd(CmdPre, 2'd0, 12'h400, 16'h0, 2'b00);
    cmd(CmdMrs, 2'd0, 12'h220, 16'h0, 2'b00);
    cmd(CmdAct, 2'd2, 12'd0, 16'h0, 2'b00);
    cmd(CmdWr, 2'd2, 12'd16, 16'h1234, 2'b00);
    cmd(CmdWr, 2'd2, 12'd16, 16'hABCD, 2'b10);
    cmd(CmdRd, 2'd2, 12'd16, 16'h0, 2'b00);
    nop();
    nop();
    check("mask_oe", data_oe, 1);
    check("mask_dat", data_out, 16'h12CD);
    nop();
    check("bl1_oe_end", data_oe, 0);

    // Protocol errors.
    perr_cnt = 0;
    oe_seen = 0;
    cmd(CmdRd, 2'd0, 12'd0, 16'h0, 2'b00);
    perr_cnt += int'(protocol_error);
    oe_seen += int'(data_oe);
    nop();
    check("perr_pulse", protocol_error, 0);
    cmd(CmdAct, 2'd2, 12'd1, 16'h0, 2'b00);
    perr_cnt += int'(protocol_error);
    cmd(CmdAct, 2'd0, 12'd0, 16'h0, 2'b00);
    check("act_ok_perr", protocol_error, 0);
    cmd(CmdAr, 2'd0, 12'd0, 16'h0, 2'b00);
    perr_cnt += int'(protocol_error);
    for (int k = 0; k < 4; k++) begin
      nop();
      oe_seen += int'(data_oe);
    end
    check("perr_count", perr_cnt, 3);
    check("perr_no_oe", oe_seen, 0);
    check("refresh_unch", refresh_count, 0);
    cmd(CmdPre, 2'd0, 12'h400, 16'h0, 2'b00);
    cmd(CmdAr, 2'd0, 12'd0, 16'h0, 2'b00);
    check("ar_ok_perr", protocol_error, 0);
    check("refresh_inc", refresh_count, 1);

    // Bad CL rejected; then CL=3 BL=8 with BST after two beats.
    cmd(CmdMrs, 2'd0, 12'h012, 16'h0, 2'b00);
    check("mrs_bad_perr", protocol_error, 1);
    cmd(CmdMrs, 2'd0, 12'h033, 16'h0, 2'b00);
    check("mrs_ok_perr", protocol_error, 0);
    cmd(CmdAct, 2'd1, 12'd5, 16'h0, 2'b00);
    cmd(CmdRd, 2'd1, 12'd0, 16'h0, 2'b00);
    nop();
    cmd(CmdBst, 2'd1, 12'd0, 16'h0, 2'b00);
    cnt = 0;
    d0 = '0;
    d1 = '0;
    for (int i = 0; i < 10; i++) begin
      nop();
      if (data_oe) begin
        if (cnt == 0) d0 = data_out;
        if (cnt == 1) d1 = data_out;
        cnt++;
      end
    end
    check("bst_beats", cnt, 2);
    check("bst_dat0", d0, 16'h0A00);
    check("bst_dat1", d1, 16'h0A01);

    // WRITE one cycle after READ flushes the read.
    cmd(CmdRd, 2'd1, 12'd0, 16'h0, 2'b00);
    cmd(CmdWr, 2'd1, 12'd8, 16'h5555, 2'b00);
    check("wr_flush_oe0", data_oe, 0);
    count_beats(12, cnt, first);
    check("wr_flush_beats", cnt, 0);

    // Async reset mid-burst.
    cmd(CmdRd, 2'd1, 12'd0, 16'h0, 2'b00);
    nop();
    nop();
    nop();
    check("pre_rst_oe", data_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_oe", data_oe, 0);
    check("async_rst_init", init_done, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_init", init_done, 0);
    cmd(CmdAct, 2'd1, 12'd5, 16'h0, 2'b00);
    check("post_rst_act", protocol_error, 0);
    cmd(CmdRd, 2'd1, 12'd0, 16'h0, 2'b00);
    count_beats(10, cnt, first);
    check("post_rst_bl", cnt, 4);
    check("post_rst_cl", first, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
